data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Memory-side responder for the neurocore 32-bit BRAM-style data/weight port (ena/wea/addra/dina/douta).
//  Serves core accesses with fixed 1-cycle read latency from a single-port array.
//  Adds a host valid/ready port (loader/readback) that uses only cycles the core leaves idle.
//  Sits between neurocore and storage; replaces the behavioural RAM model in synthesis and system benches.
// PARAMETERS
//  DEPTH      1024  words of storage (32-bit each)
//  AW         10    index width, clog2(DEPTH)
//  STARVE_MAX 256   consecutive blocked host cycles before host_starved asserts
// PORTS
//  clka          in   1   clock, all logic rising-edge
//  rsta          in   1   reset, synchronous, active-high
//  ena           in   1   core access enable
//  wea           in   4   core byte write enables, bit i -> dina[8i+7:8i]
//  addra         in   32  core word address
//  dina          in   32  core write data
//  douta         out  32  core read data, valid 1 cycle after ena
//  host_req_valid in  1   host request present
//  host_req_ready out 1   host request accepted this cycle when both high
//  host_we       in   1   1 = write full word, 0 = read
//  host_addr     in   32  host word address
//  host_wdata    in   32  host write data
//  host_rsp_valid out 1   host response present (reads and writes)
//  host_rsp_ready in  1   host consumes response
//  host_rdata    out  32  host read data (0 for writes)
//  host_starved  out  1   host blocked >= STARVE_MAX consecutive cycles
//  addr_err      out  1   sticky: any access with address >= DEPTH
// BEHAVIOUR
//  Reset (rsta=1 at edge): douta=0, host_rdata=0, host_rsp_valid=0, host_req_ready=0, host_starved=0,
//   addr_err=0, FSM->IDLE, starve counter=0. Array contents are NOT cleared. Reset mid-op drops pending host op.
//  Core port has absolute priority; it never stalls (no ready signal).
//  Core read (ena=1, wea=0): douta <= mem[addra] next edge. ena=0: douta holds previous value.
//  Core write (ena=1, wea!=0): byte-wise update; douta <= OLD word (read-first). wea=4'b0000 is a plain read.
//  Address range: addra/host_addr >= DEPTH -> write ignored, read returns 0, addr_err set (sticky until rsta).
//  Host FSM:
//   IDLE: host_req_ready=1. On valid&&ready capture we/addr/wdata -> PEND.
//   PEND: if ena=0 this cycle: perform access on array -> RESP (read data registered same edge).
//         if ena=1: stay; starve counter++ ; counter saturates at STARVE_MAX, host_starved=1 while saturated.
//   RESP: host_rsp_valid=1, host_rdata stable; on host_rsp_ready -> IDLE, counter=0, host_starved=0.
//  One outstanding host op maximum; host_req_ready=0 outside IDLE.
//  Host write is full word (all 4 bytes). Core write to same address in the PEND cycle that later issues:
//   host op issues strictly after, so host read sees core data; host write overwrites core data.
//  Latency: host op minimum 2 cycles accept-to-rsp_valid (accept, issue); +1 per blocked cycle.
// STRUCTURE
//  Shared include def.h: ENABLE/DISABLE macros, RAM data width 32, byte-enable width 4; FSM state codes local.
//  Sub-module nc_sp_ram: single-port, byte-enable, read-first array (DEPTH x 32), 1-cycle registered read.
//  Top: port mux (core vs held host request), range check, host FSM, starve counter, douta/host_rdata demux.
// TESTING
//  1. rsta 3 cycles, release; core write addr 5 data 32'hDEADBEEF wea=4'hF, read 5 -> douta=DEADBEEF 1 cycle later.
//  2. Core byte write addr 5 wea=4'b0010 dina=32'h0000AA00 -> read returns DEADAAEF; write cycle douta=old DEADBEEF.
//  3. Core ena=1 continuously 300 cycles, host read pending -> host_starved=1 after 256; ena=0 -> rsp next cycle, starved clears on rsp handshake.
//  4. Host write addr 7 = 32'h12345678, idle core -> rsp_valid 2 cycles after accept; core read 7 -> 12345678.
//  5. Core read addra=DEPTH -> douta=0, addr_err=1 stays set; write addr DEPTH+3 leaves all words unchanged.
//  6. rsta asserted while FSM in PEND -> host_req_ready=0 and rsp_valid=0 next cycle, array unmodified, IDLE after.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// rtl/data_mem_responder_pkg.sv - shared sizes, host FSM states and range helper
package data_mem_responder_pkg;

    localparam int DEPTH      = 1024;
    localparam int AW         = 10;
    localparam int STARVE_MAX = 256;
    localparam int DW         = 32;
    localparam int BW         = 4;
    localparam int CW         = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_RESP = 2'd2
    } host_state_t;

    // Word addresses at or beyond DEPTH never touch the array.
    function automatic logic addr_ok(input logic [31:0] addr);
        return addr < 32'(DEPTH);
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - core BRAM port and host valid/ready port bundle
interface data_mem_responder_if;
    import data_mem_responder_pkg::*;

    logic          ena;
    logic [BW-1:0] wea;
    logic [31:0]   addra;
    logic [DW-1:0] dina;
    logic [DW-1:0] douta;

    logic          host_req_valid;
    logic          host_req_ready;
    logic          host_we;
    logic [31:0]   host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_rsp_valid;
    logic          host_rsp_ready;
    logic [DW-1:0] host_rdata;
    logic          host_starved;
    logic          addr_err;

    modport master (
        output ena, wea, addra, dina, host_req_valid, host_we, host_addr, host_wdata, host_rsp_ready,
        input  douta, host_req_ready, host_rsp_valid, host_rdata, host_starved, addr_err
    );

    modport slave (
        input  ena, wea, addra, dina, host_req_valid, host_we, host_addr, host_wdata, host_rsp_ready,
        output douta, host_req_ready, host_rsp_valid, host_rdata, host_starved, addr_err
    );

endinterface

// File: rtl/data_mem_responder_ram.sv
// rtl/data_mem_responder_ram.sv - single-port byte-enable read-first array, registered read
module data_mem_responder_ram
    import data_mem_responder_pkg::*;
(
    input  logic          clk_i,
    input  logic          en_i,
    input  logic [BW-1:0] we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    // Old word is captured before the enabled bytes are overwritten; output holds while idle.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            rdata_q <= mem_q[addr_i];
            for (int i = 0; i < BW; i++) begin
                if (we_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - core-priority memory responder with idle-cycle host port
module data_mem_responder
    import data_mem_responder_pkg::*;
(
    input  logic                 clka,
    input  logic                 rsta,
    data_mem_responder_if.slave  bus
);

    host_state_t   state_q;
    logic          req_we_q;
    logic [31:0]   req_addr_q;
    logic [DW-1:0] req_wdata_q;
    logic          req_ready_q;
    logic          rsp_valid_q;
    logic          starved_q;
    logic [CW-1:0] starve_cnt_q;
    logic          addr_err_q;

    logic          core_rd_q;
    logic          core_oor_q;
    logic          host_rd_q;
    logic          host_rd_ok_q;
    logic [DW-1:0] douta_hold_q;
    logic [DW-1:0] rdata_hold_q;

    logic          core_ok;
    logic          host_ok;
    logic          host_issue;
    logic          ram_en;
    logic [BW-1:0] ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic [DW-1:0] douta_d;
    logic [DW-1:0] host_rdata_d;

    assign core_ok    = addr_ok(bus.addra);
    assign host_ok    = addr_ok(req_addr_q);
    assign host_issue = (state_q == ST_PEND) && !bus.ena && !rsta;

    // Core owns the array whenever it asks; the held host op only fills idle cycles.
    always_comb begin
        ram_en    = bus.ena | host_issue;
        ram_we    = '0;
        ram_addr  = req_addr_q[AW-1:0];
        ram_wdata = req_wdata_q;
        if (bus.ena) begin
            ram_addr  = bus.addra[AW-1:0];
            ram_wdata = bus.dina;
            if (core_ok) begin
                ram_we = bus.wea;
            end
        end else if (host_issue && req_we_q && host_ok) begin
            ram_we = '1;
        end
    end

    data_mem_responder_ram u_ram (
        .clk_i   (clka),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    // The shared read register belongs to whichever side accessed last edge; otherwise each side holds.
    always_comb begin
        douta_d      = douta_hold_q;
        host_rdata_d = rdata_hold_q;
        if (core_rd_q) begin
            douta_d = core_oor_q ? '0 : ram_rdata;
        end
        if (host_rd_q) begin
            host_rdata_d = host_rd_ok_q ? ram_rdata : '0;
        end
    end

    // Host FSM with starvation counter; handshake outputs are registered here.
    always_ff @(posedge clka) begin
        if (rsta) begin
            state_q      <= ST_IDLE;
            req_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            starved_q    <= 1'b0;
            starve_cnt_q <= '0;
            req_we_q     <= 1'b0;
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.host_req_valid && req_ready_q) begin
                        req_we_q    <= bus.host_we;
                        req_addr_q  <= bus.host_addr;
                        req_wdata_q <= bus.host_wdata;
                        req_ready_q <= 1'b0;
                        state_q     <= ST_PEND;
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                ST_PEND: begin
                    if (!bus.ena) begin
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end else if (starve_cnt_q != CW'(STARVE_MAX)) begin
                        starve_cnt_q <= starve_cnt_q + 1'b1;
                        starved_q    <= (starve_cnt_q == CW'(STARVE_MAX - 1));
                    end
                end
                ST_RESP: begin
                    if (bus.host_rsp_ready) begin
                        rsp_valid_q  <= 1'b0;
                        req_ready_q  <= 1'b1;
                        starve_cnt_q <= '0;
                        starved_q    <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    req_ready_q <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    // Read-data steering, output holds and the sticky range error.
    always_ff @(posedge clka) begin
        if (rsta) begin
            core_rd_q    <= 1'b0;
            core_oor_q   <= 1'b0;
            host_rd_q    <= 1'b0;
            host_rd_ok_q <= 1'b0;
            douta_hold_q <= '0;
            rdata_hold_q <= '0;
            addr_err_q   <= 1'b0;
        end else begin
            core_rd_q    <= bus.ena;
            core_oor_q   <= !core_ok;
            host_rd_q    <= host_issue;
            host_rd_ok_q <= !req_we_q && host_ok;
            douta_hold_q <= douta_d;
            rdata_hold_q <= host_rdata_d;
            if ((bus.ena && !core_ok) || (host_issue && !host_ok)) begin
                addr_err_q <= 1'b1;
            end
        end
    end

    assign bus.douta          = douta_d;
    assign bus.host_rdata     = host_rdata_d;
    assign bus.host_req_ready = req_ready_q;
    assign bus.host_rsp_valid = rsp_valid_q;
    assign bus.host_starved   = starved_q;
    assign bus.addr_err       = addr_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - scoreboard bench with reference memory model
module tb_data_mem_responder;
    import data_mem_responder_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_mem_responder_if ifc ();

    data_mem_responder dut (
        .clka (clk),
        .rsta (rst),
        .bus  (ifc)
    );

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] ref_mem [DEPTH];
    bit          known   [DEPTH];
    logic [31:0] m_douta       = '0;
    bit          m_douta_known = 1'b1;
    bit          m_err         = 1'b0;
    bit          m_starved     = 1'b0;
    bit          m_pend        = 1'b0;
    bit          m_resp        = 1'b0;
    bit          m_we          = 1'b0;
    int          m_cnt         = 0;
    logic [31:0] m_addr        = '0;
    logic [31:0] m_wdata       = '0;
    logic [31:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: no handshake within bound at %0t", name, $time);
    endtask

    // Monitor compares DUT outputs with the model, then advances the model by the inputs of the coming edge.
    always @(negedge clk) begin
        logic [AW-1:0] ai;
        logic [31:0]   pop;
        if (m_douta_known) check("douta", ifc.douta, m_douta);
        check("addr_err", 32'(ifc.addr_err), 32'(m_err));
        check("host_starved", 32'(ifc.host_starved), 32'(m_starved));
        check("rsp_valid", 32'(ifc.host_rsp_valid), 32'(m_resp));
        if (m_pend || m_resp) check("req_ready_busy", 32'(ifc.host_req_ready), 32'd0);
        if (ifc.host_rsp_valid && ifc.host_rsp_ready) begin
            if (exp_q.size() == 0) begin
                fail_timeout("unexpected_rsp");
            end else begin
                pop = exp_q.pop_front();
                check("host_rdata", ifc.host_rdata, pop);
            end
        end

        if (rst) begin
            m_douta = '0; m_douta_known = 1'b1; m_err = 1'b0; m_starved = 1'b0;
            m_cnt = 0; m_pend = 1'b0; m_resp = 1'b0;
            exp_q.delete();
        end else begin
            if (m_resp && ifc.host_rsp_ready) begin
                m_resp = 1'b0; m_cnt = 0; m_starved = 1'b0;
            end
            if (m_pend) begin
                if (!ifc.ena) begin
                    ai = m_addr[AW-1:0];
                    if (m_addr >= 32'(DEPTH)) begin
                        m_err = 1'b1;
                        exp_q.push_back(32'd0);
                    end else if (m_we) begin
                        ref_mem[ai] = m_wdata;
                        known[ai]   = 1'b1;
                        exp_q.push_back(32'd0);
                    end else begin
                        exp_q.push_back(ref_mem[ai]);
                    end
                    m_pend = 1'b0;
                    m_resp = 1'b1;
                end else begin
                    if (m_cnt < STARVE_MAX) m_cnt++;
                    m_starved = (m_cnt >= STARVE_MAX);
                end
            end
            if (ifc.ena) begin
                ai = ifc.addra[AW-1:0];
                if (ifc.addra >= 32'(DEPTH)) begin
                    m_douta = '0; m_douta_known = 1'b1; m_err = 1'b1;
                end else begin
                    m_douta = ref_mem[ai]; m_douta_known = known[ai];
                    for (int b = 0; b < 4; b++)
                        if (ifc.wea[b]) ref_mem[ai][8*b +: 8] = ifc.dina[8*b +: 8];
                    if (ifc.wea == 4'hF) known[ai] = 1'b1;
                end
            end
            if (ifc.host_req_valid && ifc.host_req_ready) begin
                m_pend = 1'b1; m_we = ifc.host_we; m_addr = ifc.host_addr; m_wdata = ifc.host_wdata;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic core(input bit en, input logic [3:0] we, input logic [31:0] a, input logic [31:0] d);
        ifc.ena = en; ifc.wea = we; ifc.addra = a; ifc.dina = d;
        cyc();
    endtask

    // Presents one host request and returns at the edge after it was accepted.
    task automatic host_req(input bit we, input logic [31:0] a, input logic [31:0] d);
        bit ok = 1'b0;
        ifc.host_req_valid = 1'b1; ifc.host_we = we; ifc.host_addr = a; ifc.host_wdata = d;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ifc.host_req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        cyc();
        ifc.host_req_valid = 1'b0;
        if (!ok) fail_timeout("host_accept");
    endtask

    initial begin
        logic [31:0] old9;
        bit          acc;
        int          busy_mode;
        ifc.ena = 1'b0; ifc.wea = '0; ifc.addra = '0; ifc.dina = '0;
        ifc.host_req_valid = 1'b0; ifc.host_we = 1'b0; ifc.host_addr = '0; ifc.host_wdata = '0;
        ifc.host_rsp_ready = 1'b0;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 32'(ifc.host_req_ready), 32'd0);
        check("reset_rsp_valid", 32'(ifc.host_rsp_valid), 32'd0);
        check("reset_douta", ifc.douta, 32'd0);
        rst = 1'b0;

        for (int a = 0; a < DEPTH; a++) core(1'b1, 4'hF, 32'(a), $urandom);
        ifc.ena = 1'b0;
        cyc();

        core(1'b1, 4'hF, 32'd5, 32'hDEADBEEF);
        core(1'b1, 4'h0, 32'd5, 32'd0);
        check("t1_read5", ifc.douta, 32'hDEADBEEF);
        core(1'b1, 4'b0010, 32'd5, 32'h0000AA00);
        check("t2_read_first", ifc.douta, 32'hDEADBEEF);
        core(1'b1, 4'h0, 32'd5, 32'd0);
        check("t2_byte_merge", ifc.douta, 32'hDEADAAEF);
        core(1'b0, 4'h0, 32'd0, 32'd0);
        check("t2_hold", ifc.douta, 32'hDEADAAEF);

        ifc.host_rsp_ready = 1'b1;
        host_req(1'b1, 32'd7, 32'h12345678);
        check("t4_rsp_not_yet", 32'(ifc.host_rsp_valid), 32'd0);
        cyc();
        check("t4_rsp_2cyc", 32'(ifc.host_rsp_valid), 32'd1);
        cyc();
        core(1'b1, 4'h0, 32'd7, 32'd0);
        check("t4_core_sees_host", ifc.douta, 32'h12345678);

        ifc.ena = 1'b1; ifc.wea = 4'h0; ifc.addra = 32'd3;
        host_req(1'b0, 32'd11, 32'd0);
        for (int i = 0; i < 255; i++) begin
            ifc.addra = 32'($urandom_range(DEPTH - 1));
            cyc();
        end
        check("t3_not_starved_255", 32'(ifc.host_starved), 32'd0);
        cyc();
        check("t3_starved_256", 32'(ifc.host_starved), 32'd1);
        repeat (44) cyc();
        ifc.ena = 1'b0;
        cyc();
        check("t3_rsp_after_release", 32'(ifc.host_rsp_valid), 32'd1);
        check("t3_starved_until_hs", 32'(ifc.host_starved), 32'd1);
        cyc();
        check("t3_starved_cleared", 32'(ifc.host_starved), 32'd0);

        core(1'b1, 4'h0, 32'(DEPTH), 32'd0);
        check("t5_oor_read", ifc.douta, 32'd0);
        check("t5_addr_err", 32'(ifc.addr_err), 32'd1);
        core(1'b1, 4'hF, 32'(DEPTH + 3), 32'hFFFFFFFF);
        core(1'b1, 4'h0, 32'd3, 32'd0);
        check("t5_alias_unchanged", ifc.douta, ref_mem[3]);
        check("t5_err_sticky", 32'(ifc.addr_err), 32'd1);

        old9 = ref_mem[9];
        ifc.ena = 1'b1; ifc.wea = 4'h0; ifc.addra = 32'd2;
        host_req(1'b1, 32'd9, 32'hCAFEF00D);
        cyc();
        ifc.ena = 1'b0;
        rst = 1'b1;
        cyc();
        check("t6_ready_low", 32'(ifc.host_req_ready), 32'd0);
        check("t6_rsp_low", 32'(ifc.host_rsp_valid), 32'd0);
        check("t6_err_cleared", 32'(ifc.addr_err), 32'd0);
        rst = 1'b0;
        cyc();
        cyc();
        check("t6_idle_ready", 32'(ifc.host_req_ready), 32'd1);
        core(1'b1, 4'h0, 32'd9, 32'd0);
        check("t6_array_kept", ifc.douta, old9);

        busy_mode = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            acc = ifc.host_req_valid && ifc.host_req_ready;
            cyc();
            if ($urandom_range(63) == 0) busy_mode = $urandom_range(2);
            ifc.ena   = (busy_mode == 2) ? 1'b1 : ($urandom_range(2) < 32'(busy_mode + 1));
            ifc.wea   = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom);
            ifc.addra = ($urandom_range(63) == 0) ? 32'(DEPTH + $urandom_range(15)) : 32'($urandom_range(DEPTH - 1));
            ifc.dina  = $urandom;
            if (acc) ifc.host_req_valid = 1'b0;
            if (!ifc.host_req_valid && $urandom_range(2) == 0) begin
                ifc.host_req_valid = 1'b1;
                ifc.host_we        = $urandom_range(1) == 1;
                ifc.host_addr      = ($urandom_range(63) == 0) ? 32'(DEPTH + $urandom_range(15)) : 32'($urandom_range(DEPTH - 1));
                ifc.host_wdata     = $urandom;
            end
            ifc.host_rsp_ready = $urandom_range(1) == 1;
        end

        @(negedge clk);
        acc = ifc.host_req_valid && ifc.host_req_ready;
        cyc();
        if (acc) ifc.host_req_valid = 1'b0;
        ifc.ena = 1'b0;
        ifc.host_rsp_ready = 1'b1;
        for (int i = 0; i < 50 && ifc.host_req_valid; i++) begin
            @(negedge clk);
            acc = ifc.host_req_ready;
            cyc();
            if (acc) ifc.host_req_valid = 1'b0;
        end
        repeat (10) cyc();
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
